// File: rtl/alu_issue_wb_if.sv
// ---------------------------------------------------------------------------
// alu_issue_wb_if
//   Instruction-in and result-out handshake bundle for alu_issue_wb.
//   master : instruction source / result consumer (drives in_*, res_ready)
//   slave  : the sequencer (drives in_ready, res_*)
//   Signals:
//     in_valid/in_ready        instruction handshake
//     in_op, in_rd, in_rs1/2   opcode, destination and source registers
//     res_valid/res_ready      result handshake
//     res_data, res_rd         captured result and its destination
//     res_illegal              captured opcode was out of range
// ---------------------------------------------------------------------------
interface alu_issue_wb_if #(
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [REG_AW-1:0] in_rd;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
    logic [REG_AW-1:0] res_rd;
    logic              res_illegal;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, res_ready,
        input  in_ready, res_valid, res_data, res_rd, res_illegal
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, res_ready,
        output in_ready, res_valid, res_data, res_rd, res_illegal
    );
endinterface

// File: rtl/alu_issue_wb.sv
// ---------------------------------------------------------------------------
// alu_issue_wb
//   Operand-fetch / write-back sequencer for an external combinational ALU.
//   Owns the 2^REG_AW x 32 register file, accepts one register-to-register
//   instruction per handshake, drives the ALU for one EXEC cycle, writes the
//   result back and presents it on a valid/ready result port.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     bus (slave)         instruction and result handshakes
//     alu_a, alu_b        ALU operands (zero outside EXEC)
//     alu_op              ALU opcode (zero outside EXEC)
//     alu_out             ALU result, combinational from alu_a/alu_b/alu_op
//     retired             count of completed result handshakes (wrapping)
//     dbg_addr, dbg_data  combinational register-file read port
// ---------------------------------------------------------------------------
module alu_issue_wb #(
    parameter int REG_AW   = 5,
    parameter int OP_MAX   = 6,
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_wb_if.slave       bus,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [4:0]          alu_op,
    input  logic [31:0]         alu_out,
    output logic [RETIRE_W-1:0] retired,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [31:0]         dbg_data
);

    localparam int         NREG     = 1 << REG_AW;
    localparam logic [4:0] OP_LIMIT = 5'(OP_MAX);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    state_t            state, state_nxt;
    logic              in_ready;
    logic              accept;
    logic [4:0]        op_q;
    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
    logic [31:0]       res_data_q;
    logic [REG_AW-1:0] res_rd_q;
    logic              res_illegal_q;
    logic [31:0]       rf [NREG];

    // ---------------- next-state / handshake decode ----------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = HOLD;
            HOLD: begin
                // A new instruction can only enter as the held result leaves.
                in_ready = bus.res_ready;
                if (bus.res_ready) state_nxt = bus.in_valid ? EXEC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept          = bus.in_valid & in_ready;
    assign bus.in_ready    = in_ready;
    assign bus.res_valid   = (state == HOLD);
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_illegal = res_illegal_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- instruction latch ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            op_q  <= bus.in_op;
            rd_q  <= bus.in_rd;
            rs1_q <= bus.in_rs1;
            rs2_q <= bus.in_rs2;
        end
    end

    // ---------------- result capture and retire count ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_illegal_q <= 1'b0;
            retired       <= '0;
        end else begin
            if (state == EXEC) begin
                res_data_q    <= alu_out;
                res_rd_q      <= rd_q;
                res_illegal_q <= (op_q > OP_LIMIT);
            end
            if (state == HOLD && bus.res_ready) retired <= retired + RETIRE_W'(1);
        end
    end

    // ---------------- register file ----------------
    // Write-back lands on the EXEC edge, so the next EXEC always reads the
    // updated value without forwarding. Entry 0 is never written, so it
    // reads as zero on both the operand and debug ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this register file must come out of reset all-zero, so it
            // is built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (state == EXEC && rd_q != '0) begin
            rf[rd_q] <= alu_out;
        end
    end

    // The ALU sees zeros outside EXEC so its output is quiet when idle.
    assign alu_a    = (state == EXEC) ? rf[rs1_q] : '0;
    assign alu_b    = (state == EXEC) ? rf[rs2_q] : '0;
    assign alu_op   = (state == EXEC) ? op_q      : '0;
    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_wb
//   Stimulus issues instructions and pushes the expected result, computed
//   from an array model of the register file, into a queue. A monitor pops
//   and compares on every result handshake, tracks the retire count, and
//   checks that a back-pressured result stays stable.
//   The bench supplies the ALU. Opcodes: 0 and, 1 add, 2 sub, 3 or, 4 xor,
//   5 shift-left, 6 nor; anything above 6 yields 0. A test-only injection
//   path overrides the ALU output to preload registers.
// ---------------------------------------------------------------------------
module tb_alu_issue_wb;

    localparam int REG_AW   = 5;
    localparam int OP_MAX   = 6;
    localparam int RETIRE_W = 4;

    typedef struct packed {
        logic [31:0]       data;
        logic [REG_AW-1:0] rd;
        logic              illegal;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [31:0]         alu_a, alu_b, alu_out, dbg_data;
    logic [4:0]          alu_op;
    logic [RETIRE_W-1:0] retired;
    logic [REG_AW-1:0]   dbg_addr = '0;
    logic                inj_en = 1'b0;
    logic [31:0]         inj_val = '0;
    logic                bp_en = 1'b0;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] rf_m [1 << REG_AW];
    int          ret_m = 0;

    always #5 clk = ~clk;

    alu_issue_wb_if #(.REG_AW(REG_AW)) bus ();

    alu_issue_wb #(
        .REG_AW  (REG_AW),
        .OP_MAX  (OP_MAX),
        .RETIRE_W(RETIRE_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .retired (retired),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            5'd0:    return a & b;
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return a << b[4:0];
            5'd6:    return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_out = inj_en ? inj_val : alu_fn(alu_op, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called on a falling edge; returns on the falling edge inside EXEC.
    task automatic issue(input logic [4:0] op, input logic [REG_AW-1:0] rd,
                         input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                         input logic use_inj, input logic [31:0] val, output int waited);
        exp_t e;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        if (use_inj) begin
            inj_en  = 1'b1;
            inj_val = val;
        end
        e.data    = use_inj ? val : alu_fn(op, rf_m[rs1], rf_m[rs2]);
        e.rd      = rd;
        e.illegal = (int'(op) > OP_MAX);
        if (rd != '0) rf_m[rd] = e.data;
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input logic [4:0] op, input logic [REG_AW-1:0] rd,
                       input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
        int w;
        issue(op, rd, rs1, rs2, 1'b0, 32'd0, w);
    endtask

    task automatic preload(input logic [REG_AW-1:0] rd, input logic [31:0] val);
        int w;
        issue(5'd0, rd, '0, '0, 1'b1, val, w);
        @(negedge clk);
        inj_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        ret_m = 0;
        for (int i = 0; i < (1 << REG_AW); i++) rf_m[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random back-pressure, driven just after the rising edge so that
    // ready-dependent signals are settled at every falling-edge sample.
    initial begin : bp_driver
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) bus.res_ready = 1'(($urandom() >> 3) & 1);
        end
    end

    initial begin : monitor
        exp_t        e;
        logic        prev_hold = 1'b0;
        logic [31:0] pd = '0;
        logic [REG_AW-1:0] prd = '0;
        logic        pil = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                check("retired", 32'(retired), 32'(ret_m));
                if (prev_hold) begin
                    check("hold_valid", 32'(bus.res_valid), 32'd1);
                    check("hold_data", bus.res_data, pd);
                    check("hold_rd", 32'(bus.res_rd), 32'(prd));
                    check("hold_illegal", 32'(bus.res_illegal), 32'(pil));
                    check("hold_in_ready", 32'(bus.in_ready), 32'(bus.res_ready));
                end
                prev_hold = 1'b0;
                if (bus.res_valid) begin
                    if (bus.res_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("res_data", bus.res_data, e.data);
                            check("res_rd", 32'(bus.res_rd), 32'(e.rd));
                            check("res_illegal", 32'(bus.res_illegal), 32'(e.illegal));
                            ret_m = (ret_m + 1) % (1 << RETIRE_W);
                        end
                    end else begin
                        prev_hold = 1'b1;
                        pd        = bus.res_data;
                        prd       = bus.res_rd;
                        pil       = bus.res_illegal;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int                w;
        int                r0;
        logic [REG_AW-1:0] rd, rs1, rs2;
        logic [4:0]        op;

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < (1 << REG_AW); i++) rf_m[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < (1 << REG_AW); i++) begin
            dbg_addr = REG_AW'(i);
            #1;
            check("rst_dbg", dbg_data, 32'd0);
        end

        // Preload and a simple add with latency check
        run(5'd0, 5'd1, 5'd0, 5'd0);
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        drain();
        run(5'd1, 5'd3, 5'd1, 5'd2);
        check("lat_exec_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("lat_hold_valid", 32'(bus.res_valid), 32'd1);
        check("add_data", bus.res_data, 32'd12);
        check("add_rd", 32'(bus.res_rd), 32'd3);
        dbg_addr = 5'd3;
        #1;
        check("add_wb", dbg_data, 32'd12);
        drain();

        // Back-to-back dependency
        preload(5'd1, 32'hFFFF_FFFF);
        preload(5'd2, 32'd1);
        drain();
        run(5'd1, 5'd4, 5'd1, 5'd2);
        issue(5'd6, 5'd5, 5'd4, 5'd2, 1'b0, 32'd0, w);
        check("b2b_wait", 32'(w), 32'd1);
        @(negedge clk);
        check("dep_data", bus.res_data, 32'hFFFF_FFFE);
        drain();

        // Back-pressure
        bus.res_ready = 1'b0;
        run(5'd4, 5'd7, 5'd1, 5'd2);
        w = 0;
        while (!bus.res_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid", 32'(bus.res_valid), 32'd1);
        r0 = int'(retired);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_retired", 32'(retired), 32'(r0));
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ret", 32'(retired), 32'((r0 + 1) % (1 << RETIRE_W)));
        check("bp_idle_valid", 32'(bus.res_valid), 32'd0);
        check("bp_idle_ready", 32'(bus.in_ready), 32'd1);

        // Edge ops: write to r0, illegal op, then legal again
        preload(5'd1, 32'd3);
        preload(5'd2, 32'd5);
        run(5'd2, 5'd0, 5'd1, 5'd2);
        @(negedge clk);
        check("r0_res_data", bus.res_data, 32'hFFFF_FFFE);
        drain();
        dbg_addr = 5'd0;
        #1;
        check("r0_still_zero", dbg_data, 32'd0);
        run(5'd9, 5'd8, 5'd1, 5'd2);
        @(negedge clk);
        check("illegal_flag", 32'(bus.res_illegal), 32'd1);
        check("illegal_data", bus.res_data, 32'd0);
        run(5'd1, 5'd9, 5'd1, 5'd2);
        @(negedge clk);
        check("legal_flag", 32'(bus.res_illegal), 32'd0);
        drain();

        // Reset during EXEC drops the write-back
        run(5'd1, 5'd6, 5'd1, 5'd2);
        do_reset();
        dbg_addr = 5'd6;
        #1;
        check("rst_exec_r6", dbg_data, 32'd0);
        check("rst_exec_valid", 32'(bus.res_valid), 32'd0);
        check("rst_exec_retired", 32'(retired), 32'd0);
        check("rst_exec_ready", 32'(bus.in_ready), 32'd1);

        // Retire counter wraps after 2^RETIRE_W handshakes
        for (int i = 0; i < (1 << RETIRE_W); i++) begin
            op  = 5'($urandom_range(0, 6));
            rd  = REG_AW'($urandom_range(0, 7));
            rs1 = REG_AW'($urandom_range(0, 7));
            rs2 = REG_AW'($urandom_range(0, 7));
            run(op, rd, rs1, rs2);
        end
        drain();
        check("retired_wrap", 32'(retired), 32'd0);

        // Randomised traffic with random back-pressure
        bp_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rd  = REG_AW'($urandom_range(0, 7));
            rs1 = REG_AW'($urandom_range(0, 7));
            rs2 = REG_AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                preload(rd, $urandom());
            end else begin
                op = 5'($urandom_range(0, 8));
                run(op, rd, rs1, rs2);
            end
        end
        drain();
        bp_en = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b1;
        drain();

        for (int i = 0; i < (1 << REG_AW); i++) begin
            dbg_addr = REG_AW'(i);
            #1;
            check("final_rf", dbg_data, rf_m[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
